quad_step_decoder: RTL

//  - Upstream stage of the 4-bit up/down counter: turns raw quadrature encoder

---
 rtl/qdec_pkg.sv | 27 ++
 rtl/qdec_debounce.sv | 55 +++++
 rtl/quad_step_decoder.sv | 101 ++++++++++
 3 files changed

// File: rtl/qdec_pkg.sv
// Shared types, phase encodings and phase-order helper for the quadrature
// step decoder. Build option QDEC_X4_EN (in quad_step_decoder) selects x4 decode.
package qdec_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic {INIT, TRACK} qdec_state_t;

  // Phase encodings {A,B} in up-count order
  localparam quad_t PH0 = 2'b00;
  localparam quad_t PH1 = 2'b01;
  localparam quad_t PH2 = 2'b11;
  localparam quad_t PH3 = 2'b10;

  // Up-count successor of a phase; the reverse relation gives down-count
  function automatic quad_t next_phase(input quad_t ph);
    quad_t nxt;
    case (ph)
      PH0:     nxt = PH1;
      PH1:     nxt = PH2;
      PH2:     nxt = PH3;
      default: nxt = PH0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/qdec_debounce.sv
// One encoder channel: SYNC_STAGES-flop synchronizer followed by a debounce
// counter. 'stable' reports that the synchronized input has agreed with the
// filtered value for DEB_CYCLES cycles, which the top uses to leave INIT.
module qdec_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int DEB_W       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic filt,
  output logic stable
);

  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic [DEB_W-1:0]       cnt;
  logic [DEB_W-1:0]       stab_cnt;

  assign sync   = sync_q[SYNC_STAGES-1];
  assign stable = (stab_cnt == DEB_MAX);

  // Metastability chain; the asynchronous pin enters at bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  // Debounce: count disagreeing cycles, adopt the new level once the count
  // has reached DEB_CYCLES; any agreeing cycle discards the pending change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else if (sync == filt) begin
      cnt  <= '0;
    end else if (cnt == DEB_MAX) begin
      filt <= sync;
      cnt  <= '0;
    end else begin
      cnt  <= cnt + DEB_W'(1);
    end
  end

  // Stability count used only for the INIT exit; saturates at DEB_CYCLES
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                stab_cnt <= '0;
    else if (sync != filt)     stab_cnt <= '0;
    else if (stab_cnt != DEB_MAX) stab_cnt <= stab_cnt + DEB_W'(1);
  end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature step decoder: two debounced channels feed a phase tracker that
// emits a one-cycle step pulse (en), a held direction (dwn) and error flags
// for illegal two-bit phase jumps.
// Build option: define QDEC_X4_EN for x4 decode (every legal transition
// steps); otherwise x1 decode (only legal transitions into phase 00 step).
module quad_step_decoder
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter int DEB_W       = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_in,
  input  logic b_in,
  input  logic err_clr,
  output logic en,
  output logic dwn,
  output logic err,
  output logic err_sticky
);

  logic        a_filt, b_filt, a_stable, b_stable;
  quad_t       filt, prev_q, prev_d;
  qdec_state_t state_q, state_d;
  logic        en_d, dwn_d, err_d, sticky_d;
  logic        step_ok;

  qdec_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .din(a_in), .filt(a_filt), .stable(a_stable)
  );

  qdec_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .din(b_in), .filt(b_filt), .stable(b_stable)
  );

  assign filt = {a_filt, b_filt};

`ifdef QDEC_X4_EN
  assign step_ok = 1'b1;
`else
  // x1: only legal arrivals at phase 00 produce a step
  assign step_ok = (filt == PH0);
`endif

  // Next-state and output decode; defaults hold direction and drop pulses
  always_comb begin
    state_d  = state_q;
    prev_d   = prev_q;
    en_d     = 1'b0;
    dwn_d    = dwn;
    err_d    = 1'b0;
    sticky_d = err_sticky & ~err_clr;
    case (state_q)
      INIT: begin
        if (a_stable && b_stable) begin
          prev_d  = filt;
          state_d = TRACK;
        end
      end
      TRACK: begin
        prev_d = filt;
        if (filt != prev_q) begin
          if (filt == next_phase(prev_q)) begin
            en_d = step_ok;
            if (step_ok) dwn_d = 1'b0;
          end else if (prev_q == next_phase(filt)) begin
            en_d = step_ok;
            if (step_ok) dwn_d = 1'b1;
          end else begin
            // both channels moved at once: set has priority over err_clr
            err_d    = 1'b1;
            sticky_d = 1'b1;
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  // State, previous phase and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      prev_q     <= PH0;
      en         <= 1'b0;
      dwn        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      en         <= en_d;
      dwn        <= dwn_d;
      err        <= err_d;
      err_sticky <= sticky_d;
    end
  end

endmodule
